// File: rtl/rvfpm_pkg.sv
// Shared types and constants for the rvfpm coprocessor issue path.
// The entry width fixes the integer operand width carried through the issue buffer.
package rvfpm_pkg;

  localparam int unsigned ENTRY_XLEN = 32;
  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RD_MSB     = 11;

  typedef struct packed {
    logic [31:0]           instr;
    logic [ENTRY_XLEN-1:0] rs1;
  } issue_entry_t;

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction

endpackage

// File: rtl/fpu_issue_fifo.sv
// Synchronous FIFO with registered full/empty flags; push on full and pop on
// empty are ignored, and there is no bypass from write to read.
module fpu_issue_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge ck) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == CNT_W'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // NOTE: storage is not reset; the pointers and flags alone define which entries are live.
  always_ff @(posedge ck) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Core-side issue/result controller: buffers FP instructions, allocates X-interface IDs
// strictly in order, tracks them in flight and returns FPU results as register write-backs.
module fpu_issue_ctrl
  import rvfpm_pkg::*;
#(
  parameter int X_ID_WIDTH = 4,
  parameter int XLEN       = ENTRY_XLEN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_rs1,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [31:0]           issue_instr,
  output logic [X_ID_WIDTH-1:0] issue_id,
  output logic [XLEN-1:0]       issue_rs1,
  input  logic                  result_valid,
  output logic                  result_ready,
  input  logic [X_ID_WIDTH-1:0] result_id,
  input  logic [XLEN-1:0]       result_data,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_rd,
  output logic [X_ID_WIDTH-1:0] wb_id,
  output logic [XLEN-1:0]       wb_data,
  output logic [X_ID_WIDTH:0]   outstanding,
  output logic                  err_bad_id
);

  localparam int NUM_IDS = 1 << X_ID_WIDTH;
  localparam int OUT_W   = X_ID_WIDTH + 1;

  issue_entry_t push_entry, head;
  logic         fifo_full, fifo_empty;

  logic [X_ID_WIDTH-1:0] next_id;
  logic [NUM_IDS-1:0]    inflight, inflight_next;
  logic [4:0]            rd_table [NUM_IDS];

  logic issue_fire, result_fire, retire, bad_result;

  assign push_entry = '{instr: in_instr, rs1: in_rs1};

  fpu_issue_fifo #(
    .WIDTH($bits(issue_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .ck   (ck),
    .rst  (rst),
    .push (in_valid),
    .wdata(push_entry),
    .pop  (issue_fire),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign in_ready = !fifo_full;

  // Allocation never skips ahead: a busy next_id stalls the whole issue stream.
  assign issue_valid = !fifo_empty && !inflight[next_id];
  assign issue_fire  = issue_valid && issue_ready;
  assign issue_id    = next_id;
  assign issue_instr = issue_valid ? head.instr : '0;
  assign issue_rs1   = issue_valid ? head.rs1   : '0;

  assign result_ready = !wb_valid || wb_ready;
  assign result_fire  = result_valid && result_ready;
  assign retire       = result_fire && inflight[result_id];
  assign bad_result   = result_fire && !inflight[result_id];

  // A retiring ID and the allocated ID can never coincide, so set and clear are independent.
  always_comb begin
    inflight_next = inflight;
    if (issue_fire) inflight_next[next_id]   = 1'b1;
    if (retire)     inflight_next[result_id] = 1'b0;
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      inflight    <= '0;
      next_id     <= '0;
      outstanding <= '0;
      err_bad_id  <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_id       <= '0;
      wb_data     <= '0;
    end else begin
      inflight <= inflight_next;
      if (issue_fire) next_id <= next_id + X_ID_WIDTH'(1);

      case ({issue_fire, retire})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (bad_result) err_bad_id <= 1'b1;

      if (retire) begin
        wb_valid <= 1'b1;
        wb_rd    <= rd_table[result_id];
        wb_id    <= result_id;
        wb_data  <= result_data;
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (issue_fire) rd_table[next_id] <= rd_of(head.instr);
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Scoreboard bench for fpu_issue_ctrl: directed scenarios followed by random traffic,
// checked every cycle against a queue/array reference model of the issue/result rules.
module tb_fpu_issue_ctrl;

  localparam int IDW   = 2;
  localparam int NIDS  = 1 << IDW;
  localparam int DEPTH = 4;

  logic            ck = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [31:0]     in_instr, in_rs1;
  logic            issue_valid, issue_ready;
  logic [31:0]     issue_instr, issue_rs1;
  logic [IDW-1:0]  issue_id;
  logic            result_valid, result_ready;
  logic [IDW-1:0]  result_id;
  logic [31:0]     result_data;
  logic            wb_valid, wb_ready;
  logic [4:0]      wb_rd;
  logic [IDW-1:0]  wb_id;
  logic [31:0]     wb_data;
  logic [IDW:0]    outstanding;
  logic            err_bad_id;

  fpu_issue_ctrl #(.X_ID_WIDTH(IDW), .XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
    .ck(ck), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_rs1(in_rs1),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
    .issue_id(issue_id), .issue_rs1(issue_rs1),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_id(wb_id), .wb_data(wb_data),
    .outstanding(outstanding), .err_bad_id(err_bad_id)
  );

  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending instructions, ID ownership and expected write-backs.
  typedef struct { logic [31:0] instr; logic [31:0] rs1; } pend_t;
  typedef struct { logic [4:0] rd; logic [IDW-1:0] id; logic [31:0] data; } wb_t;

  pend_t          pend_q[$];
  wb_t            exp_wb_q[$];
  bit [NIDS-1:0]  m_inflight;
  logic [4:0]     m_rd [NIDS];
  logic [IDW-1:0] m_next;
  int             m_count;
  bit             m_err;
  bit             exp_iv;

  always @(negedge ck) begin
    if (rst !== 1'b1) begin
      pend_q.delete();
      exp_wb_q.delete();
      m_inflight = '0;
      m_next     = '0;
      m_count    = 0;
      m_err      = 1'b0;
    end else begin
      check("in_ready", in_ready, pend_q.size() < DEPTH);
      exp_iv = (pend_q.size() != 0) && !m_inflight[m_next];
      check("issue_valid", issue_valid, exp_iv);
      if (issue_valid && exp_iv) begin
        check("issue_instr", issue_instr, pend_q[0].instr);
        check("issue_rs1", issue_rs1, pend_q[0].rs1);
        check("issue_id", issue_id, m_next);
      end
      check("outstanding", outstanding, m_count);
      check("err_bad_id", err_bad_id, m_err);
      check("wb_valid", wb_valid, exp_wb_q.size() != 0);
      if (wb_valid && exp_wb_q.size() != 0) begin
        check("wb_rd", wb_rd, exp_wb_q[0].rd);
        check("wb_id", wb_id, exp_wb_q[0].id);
        check("wb_data", wb_data, exp_wb_q[0].data);
      end
      check("result_ready", result_ready, (exp_wb_q.size() == 0) || wb_ready);

      // Advance the model by the handshakes that complete at the coming edge.
      if (wb_valid && wb_ready && exp_wb_q.size() != 0) void'(exp_wb_q.pop_front());
      if (result_valid && result_ready) begin
        if (m_inflight[result_id]) begin
          exp_wb_q.push_back('{rd: m_rd[result_id], id: result_id, data: result_data});
          m_inflight[result_id] = 1'b0;
          m_count--;
        end else begin
          m_err = 1'b1;
        end
      end
      if (issue_valid && issue_ready && pend_q.size() != 0) begin
        m_inflight[m_next] = 1'b1;
        m_rd[m_next]       = pend_q[0].instr[11:7];
        void'(pend_q.pop_front());
        m_next = m_next + 1'b1;
        m_count++;
      end
      if (in_valid && in_ready) pend_q.push_back('{instr: in_instr, rs1: in_rs1});
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input logic [4:0] rd);
    logic [31:0] w;
    w = $urandom & 32'hFFFF_F000;
    return w | {20'b0, rd, 7'h53};
  endfunction

  task automatic push_one(input logic [31:0] instr, input logic [31:0] rs1);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_rs1   = rs1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_result(input logic [IDW-1:0] id, input logic [31:0] data);
    int n;
    n = 0;
    result_valid = 1'b1;
    result_id    = id;
    result_data  = data;
    while (!result_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("result_timeout", result_ready, 1);
    tick();
    result_valid = 1'b0;
  endtask

  task automatic wait_outstanding(input int val);
    int n;
    n = 0;
    while (outstanding != val && n < 50) begin
      tick();
      n++;
    end
    check("wait_outstanding", outstanding, val);
  endtask

  task automatic pick_inflight(output bit found, output logic [IDW-1:0] id);
    int start;
    found = 1'b0;
    id    = '0;
    start = $urandom_range(NIDS - 1);
    for (int k = 0; k < NIDS; k++) begin
      if (!found && m_inflight[(start + k) % NIDS]) begin
        found = 1'b1;
        id    = IDW'((start + k) % NIDS);
      end
    end
  endtask

  logic [31:0] bp_first;
  int          bp_cnt;
  bit          found;
  logic [IDW-1:0] pid;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_instr = '0; in_rs1 = '0;
    issue_ready = 1'b0;
    result_valid = 1'b0; result_id = '0; result_data = '0;
    wb_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b1;

    // Reset with queued work discards it.
    for (int i = 0; i < 3; i++) push_one(mk_instr(5'(i + 4)), $urandom);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_issue_id", issue_id, 0);
    check("rst_issue_instr", issue_instr, 0);
    check("rst_issue_rs1", issue_rs1, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_outstanding", outstanding, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_err", err_bad_id, 0);

    // Single operation round trip.
    issue_ready = 1'b1;
    push_one(32'h0020_8053, 32'h3F80_0000);
    check("single_issue_valid", issue_valid, 1);
    check("single_issue_id", issue_id, 0);
    check("single_issue_instr", issue_instr, 32'h0020_8053);
    tick();
    send_result(0, 32'h4000_0000);
    check("single_wb_valid", wb_valid, 1);
    check("single_wb_rd", wb_rd, 0);
    check("single_wb_data", wb_data, 32'h4000_0000);
    check("single_outstanding", outstanding, 0);
    tick();

    // Out-of-order returns: ids 1,2,3 hold rd 1,2,3.
    for (int i = 1; i <= 3; i++) push_one(mk_instr(5'(i)), $urandom);
    wait_outstanding(3);
    send_result(3, 32'hAAAA_0003);
    check("ooo_out_a", outstanding, 2);
    check("ooo_rd_a", wb_rd, 3);
    send_result(1, 32'hAAAA_0001);
    check("ooo_out_b", outstanding, 1);
    check("ooo_rd_b", wb_rd, 1);
    send_result(2, 32'hAAAA_0002);
    check("ooo_out_c", outstanding, 0);
    check("ooo_rd_c", wb_rd, 2);
    tick();

    // ID exhaustion: four issue, fifth waits for id 0 to retire.
    for (int i = 0; i < 5; i++) push_one(mk_instr(5'(i + 10)), $urandom);
    wait_outstanding(4);
    repeat (2) tick();
    check("exh_stall", issue_valid, 0);
    send_result(0, 32'h1234_5678);
    check("exh_reissue_valid", issue_valid, 1);
    check("exh_reissue_id", issue_id, 0);
    tick();
    for (int i = 1; i <= 4; i++) send_result(IDW'(i % NIDS), $urandom);
    wait_outstanding(0);

    // Issue backpressure fills the buffer and holds the head.
    issue_ready = 1'b0;
    bp_cnt = 0;
    bp_first = mk_instr(5'd21);
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin
        in_instr = (i == 0) ? bp_first : mk_instr(5'(22 + i));
        in_rs1   = $urandom;
        tick();
        bp_cnt++;
      end
    end
    in_valid = 1'b0;
    check("bp_depth", bp_cnt, DEPTH);
    repeat (5) tick();
    check("bp_hold_valid", issue_valid, 1);
    check("bp_hold_instr", issue_instr, bp_first);
    check("bp_hold_id", issue_id, 1);
    issue_ready = 1'b1;
    wait_outstanding(4);

    // Write-back backpressure stalls results and holds wb.
    wb_ready = 1'b0;
    send_result(1, 32'hBEEF_0001);
    result_valid = 1'b1;
    result_id    = 2;
    result_data  = 32'hBEEF_0002;
    repeat (3) tick();
    check("wbbp_result_ready", result_ready, 0);
    check("wbbp_wb_valid", wb_valid, 1);
    check("wbbp_wb_data", wb_data, 32'hBEEF_0001);
    check("wbbp_wb_id", wb_id, 1);
    wb_ready = 1'b1;
    tick();
    result_valid = 1'b0;
    send_result(3, $urandom);
    send_result(0, $urandom);
    wait_outstanding(0);
    tick();

    // Result for an ID not in flight.
    send_result(3, 32'hDEAD_BEEF);
    check("bad_err", err_bad_id, 1);
    check("bad_no_wb", wb_valid, 0);
    check("bad_outstanding", outstanding, 0);
    repeat (3) tick();
    check("bad_sticky", err_bad_id, 1);

    // Random traffic with one mid-run reset.
    for (int c = 0; c < 1500; c++) begin
      if (c == 700) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end
      in_valid    = ($urandom_range(2) != 0);
      in_instr    = $urandom;
      in_rs1      = $urandom;
      issue_ready = ($urandom_range(3) != 0);
      wb_ready    = ($urandom_range(3) != 0);
      result_data = $urandom;
      pick_inflight(found, pid);
      if ($urandom_range(2) == 0) begin
        result_valid = 1'b0;
      end else if (found && $urandom_range(19) != 0) begin
        result_valid = 1'b1;
        result_id    = pid;
      end else begin
        result_valid = 1'b1;
        result_id    = IDW'($urandom_range(NIDS - 1));
      end
      tick();
    end

    // Drain everything still queued or in flight.
    in_valid = 1'b0;
    issue_ready = 1'b1;
    wb_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (pend_q.size() == 0 && m_count == 0 && exp_wb_q.size() == 0) break;
      pick_inflight(found, pid);
      result_valid = found;
      result_id    = pid;
      result_data  = $urandom;
      tick();
    end
    result_valid = 1'b0;
    tick();
    check("drain_outstanding", outstanding, 0);
    check("drain_wb_valid", wb_valid, 0);
    check("drain_issue_valid", issue_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Core-side issue/result controller for the rvfpm coprocessor: accepts FP instructions with their integer operand from the core, assigns each an X-interface ID, and issues them to the FPU over a valid/ready handshake. It tracks in-flight IDs, accepts FPU results (possibly out of order), and returns them to the core as register write-backs with the destination register restored. It is the initiator counterpart of the FPU's issue/result port; the same interface is what the bench drives.

## Interface
- X_ID_WIDTH, 4: ID width; 2**X_ID_WIDTH IDs available.
- XLEN, 32: integer register width.
- FIFO_DEPTH, 4: issue buffer entries (power of two, ≥2).

- ck  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid / in_ready  in / out  1  core instruction handshake.
- in_instr  in  32  FP instruction word.
- in_rs1  in  XLEN  integer operand (the data_fromXReg value).
- issue_valid / issue_ready  out / in  1  FPU issue handshake; issue_ready is the FPU's fpu_ready.
- issue_instr  out  32  issued instruction.
- issue_id  out  X_ID_WIDTH  assigned ID.
- issue_rs1  out  XLEN  operand.
- result_valid / result_ready  in / out  1  FPU result handshake; result_valid is toXReg_valid.
- result_id  in  X_ID_WIDTH  returning ID (id_out).
- result_data  in  XLEN  data_toXReg.
- wb_valid / wb_ready  out / in  1  write-back handshake to the core.
- wb_rd  out  5  destination register.
- wb_id  out  X_ID_WIDTH  retired ID.
- wb_data  out  XLEN  result.
- outstanding  out  X_ID_WIDTH+1  in-flight count.
- err_bad_id  out  1  sticky: result for an ID not in flight.

## Operation
- A FIFO of {instr, rs1} entries; in_ready = FIFO not full. A push occurs on in_valid && in_ready.
- next_id counter, and an inflight[2**X_ID_WIDTH] bitmap plus rd table indexed by ID.
- Issue stage:
  - issue_valid = FIFO non-empty && !inflight[next_id].
  - Payload is the FIFO head plus next_id.
  - On issue_valid && issue_ready: pop the FIFO, set inflight[next_id], store rd = instr[11:7], and increment next_id (wrapping at 2**X_ID_WIDTH).
  - IDs are allocated strictly in order. The block stalls while the next ID is still in flight; it never skips to a free ID.
- Result stage:
  - A single output register drives the wb_* outputs.
  - result_ready = !wb_valid || wb_ready.
  - On result_valid && result_ready with inflight[result_id] set: clear the bit, then load wb_rd from the table, wb_id = result_id, wb_data = result_data, and wb_valid = 1.
  - If the bit is clear: drop the result, set err_bad_id (cleared only by reset), and leave wb unchanged.
  - wb_valid clears on wb_ready when no new result is loaded.
- outstanding: +1 on issue, −1 on valid retire; both in the same cycle leaves it unchanged. It always equals popcount(inflight).
- Same-cycle issue and retire: allocation reads the pre-update bitmap, so an ID retiring this cycle is issuable next cycle, not this one.
- Pushes and pops may occur in the same cycle: a full FIFO with a pop still has in_ready = 0 (registered full flag); an empty FIFO cannot bypass to issue.

## Timing
- Reset (rst = 0 at an edge): the FIFO is emptied; inflight, next_id, outstanding, wb_valid, issue_valid, and err_bad_id are all 0; in_ready = 1; payload outputs are 0.
- Reset mid-operation discards all queued and in-flight state. Late results after reset flag err_bad_id.
- Input to issue: the earliest issue_valid is the cycle after the push (1-cycle latency).
- Issue handshake: once asserted, issue_valid and its payload hold stable until issue_ready is sampled high. At full throughput, one issue per cycle.
- Result to write-back: 1 cycle. Back-to-back results are accepted every cycle while wb_ready = 1.
- With wb_valid && !wb_ready: result_ready = 0 and the wb_* outputs hold.

## Structure
- rvfpm_pkg holds:
  - the typedef issue_entry_t {instr, rs1};
  - the RD_LSB/RD_MSB constants (7/11).
- Sub-module fpu_issue_fifo: a parameterized synchronous FIFO (push/pop/full/empty, registered flags). The top holds the allocator, scoreboard, and write-back register.

## Test plan
- Reset: push 3 instructions, pull rst low for 1 cycle → all outputs at their reset values, next issue_id = 0, outstanding = 0.
- Single op: push instr 0x0020_8053 (rd = 0) with rs1 = 0x3F80_0000 → issue_valid next cycle with id 0. Return id 0 with data 0x4000_0000 → wb_valid one cycle later, wb_rd = 0, wb_data = 0x4000_0000, outstanding back to 0.
- Out-of-order: issue ids 0, 1, 2, then return 2, 0, 1 → wb in that order with the correct rd for each, and outstanding counts 3→2→1→0.
- ID exhaustion (X_ID_WIDTH = 2): issue 4 ops without returns → issue_valid = 0 with the FIFO non-empty. Return id 0 → id 0 reissues the cycle after retire.
- Backpressure: hold issue_ready = 0 for 5 cycles → payload stable and in_ready drops after FIFO_DEPTH pushes. Hold wb_ready = 0 → result_ready = 0 and wb held.
- Bad ID: return id 3 when not in flight → err_bad_id = 1 and stays set, no wb_valid, and outstanding is unchanged.
